// File: rtl/bf_stream_tx_pkg.sv
// Shared constants for the butterfly serial stream transmitter:
// FSM encodings, word indices within a packed job, and packed job width.
package bf_stream_tx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_XA     = 3'd1;
   localparam logic [2:0] ST_XB     = 3'd2;
   localparam logic [2:0] ST_W      = 3'd3;
   localparam logic [2:0] ST_GAP_XA = 3'd4;
   localparam logic [2:0] ST_GAP_XB = 3'd5;
   localparam logic [2:0] ST_GAP_W  = 3'd6;

   localparam int WORD_XA = 0;
   localparam int WORD_XB = 1;
   localparam int WORD_W  = 2;

   // Packed job layout, LSB first: xa, xb, w, m.
   function automatic int job_width(input int width, input int mwidth);
      return width * 3 + mwidth;
   endfunction

endpackage

// File: rtl/bf_stream_tx_if.sv
// Parallel job input and serial stream output bundle of bf_stream_tx.
interface bf_stream_tx_if #(
   parameter int WIDTH  = 32,
   parameter int MWIDTH = 1
);
   logic [WIDTH-1:0]  in_xa;
   logic [WIDTH-1:0]  in_xb;
   logic [WIDTH-1:0]  in_w;
   logic [MWIDTH-1:0] in_m;
   logic              in_nd;
   logic              in_full;
   logic [WIDTH-1:0]  out_data;
   logic              out_nd;
   logic [MWIDTH-1:0] out_m;
   logic              error;

   modport master (
      output in_xa, in_xb, in_w, in_m, in_nd,
      input  in_full, out_data, out_nd, out_m, error
   );

   modport slave (
      input  in_xa, in_xb, in_w, in_m, in_nd,
      output in_full, out_data, out_nd, out_m, error
   );
endinterface

// File: rtl/bf_stream_tx_job_fifo.sv
// bf_job_fifo: single-clock FIFO of packed jobs with registered read data;
// pointers carry an extra MSB so full/empty are distinguished on wrap.
module bf_job_fifo #(
   parameter int WIDTH_JOB = 97,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [WIDTH_JOB-1:0] wr_data,
   input  logic                 rd_en,
   output logic [WIDTH_JOB-1:0] rd_data,
   output logic                 full,
   output logic                 empty
);
   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

   logic [WIDTH_JOB-1:0] mem [DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;
   logic                 do_wr;
   logic                 do_rd;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/bf_stream_tx.sv
// Butterfly job serialiser: buffers (xa, xb, w, m) jobs and emits xa, xb, w
// one word per beat with GAP idle cycles after each. Option: BF_STREAM_TX_ZERO_DROP_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | FIFO empty, nothing to send
// XA        | job popped; emit xa (or discard it, see sync rule)
// XB        | emit xb
// W         | emit w; pop next job if one is waiting
// GAP_XA    | idle cycles after xa
// GAP_XB    | idle cycles after xb
// GAP_W     | idle cycles after w; then next job or IDLE
module bf_stream_tx
   import bf_stream_tx_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int MWIDTH = 1,
   parameter int DEPTH  = 4,
   parameter int GAP    = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   bf_stream_tx_if.slave bus
);
   localparam int         WJ       = job_width(WIDTH, MWIDTH);
   localparam logic [2:0] GAP_LOAD = 3'(GAP - 1);

   logic [WJ-1:0]     rd_job;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic [2:0]        state_q, state_d, st_after_w;
   logic [2:0]        gap_q, gap_d;
   logic              emit, emit_xa, drop_zero;
   logic              synced_q, error_q, out_nd_q;
   logic [WIDTH-1:0]  emit_word, out_data_q;
   logic [WIDTH-1:0]  rd_xa, rd_xb, rd_w;
   logic [MWIDTH-1:0] rd_m, out_m_q;

   bf_job_fifo #(.WIDTH_JOB(WJ), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bus.in_nd),
      .wr_data ({bus.in_m, bus.in_w, bus.in_xb, bus.in_xa}),
      .rd_en   (pop),
      .rd_data (rd_job),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign rd_xa = rd_job[WORD_XA*WIDTH +: WIDTH];
   assign rd_xb = rd_job[WORD_XB*WIDTH +: WIDTH];
   assign rd_w  = rd_job[WORD_W*WIDTH +: WIDTH];
   assign rd_m  = rd_job[3*WIDTH +: MWIDTH];

   // An xa of zero before the first frame would be invisible to the receiver.
`ifdef BF_STREAM_TX_ZERO_DROP_EN
   assign drop_zero = (state_q == ST_XA) && !synced_q && (rd_xa == '0);
`else
   logic unused_synced;
   assign drop_zero     = 1'b0;
   assign unused_synced = synced_q;
`endif

   assign st_after_w = fifo_empty ? ST_IDLE : ST_XA;
   // Every entry into XA (including XA->XA after a discard) consumes one job.
   assign pop = (state_d == ST_XA);

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      emit      = 1'b0;
      emit_xa   = 1'b0;
      emit_word = out_data_q;
      case (state_q)
         ST_IDLE: state_d = st_after_w;
         ST_XA: begin
            if (drop_zero) begin
               state_d = st_after_w;
            end else begin
               emit      = 1'b1;
               emit_xa   = 1'b1;
               emit_word = rd_xa;
               if (GAP == 0) state_d = ST_XB;
               else begin
                  state_d = ST_GAP_XA;
                  gap_d   = GAP_LOAD;
               end
            end
         end
         ST_XB: begin
            emit      = 1'b1;
            emit_word = rd_xb;
            if (GAP == 0) state_d = ST_W;
            else begin
               state_d = ST_GAP_XB;
               gap_d   = GAP_LOAD;
            end
         end
         ST_W: begin
            emit      = 1'b1;
            emit_word = rd_w;
            if (GAP == 0) state_d = st_after_w;
            else begin
               state_d = ST_GAP_W;
               gap_d   = GAP_LOAD;
            end
         end
         ST_GAP_XA: if (gap_q == 3'd0) state_d = ST_XB;      else gap_d = gap_q - 3'd1;
         ST_GAP_XB: if (gap_q == 3'd0) state_d = ST_W;       else gap_d = gap_q - 3'd1;
         ST_GAP_W:  if (gap_q == 3'd0) state_d = st_after_w; else gap_d = gap_q - 3'd1;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gap_q      <= 3'd0;
         synced_q   <= 1'b0;
         error_q    <= 1'b0;
         out_nd_q   <= 1'b0;
         out_data_q <= '0;
         out_m_q    <= '0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         out_nd_q   <= emit;
         out_data_q <= emit_word;
         out_m_q    <= emit_xa ? rd_m : '0;
         if (emit_xa) synced_q <= 1'b1;
         if (drop_zero || (bus.in_nd && fifo_full)) error_q <= 1'b1;
      end
   end

   assign bus.in_full  = fifo_full;
   assign bus.out_data = out_data_q;
   assign bus.out_nd   = out_nd_q;
   assign bus.out_m    = out_m_q;
   assign bus.error    = error_q;

endmodule
